// File: rtl/barrett_mu_precompute_if.sv
// Modulus/Barrett-constant handoff bundle between the precompute block and the reducer.
interface barrett_mu_precompute_if #(
  parameter int W = 64
);
  logic         start_i;
  logic [W-1:0] m_i;
  logic         ready_i;
  logic         busy_o;
  logic         valid_o;
  logic [W-1:0] m_o;
  logic [W-1:0] mu_o;
  logic         err_o;

  modport slave (
    input  start_i, m_i, ready_i,
    output busy_o, valid_o, m_o, mu_o, err_o
  );

  modport master (
    output start_i, m_i, ready_i,
    input  busy_o, valid_o, m_o, mu_o, err_o
  );
endinterface

// File: rtl/barrett_mu_precompute.sv
// Computes mu = floor(2^SHIFT / m) by restoring division, one quotient bit per cycle; result valid SHIFT+2 cycles after start.
// Result pair held in output registers until ready_i; start_i is ignored while busy.
module barrett_mu_precompute #(
  parameter int W     = 64,
  parameter int SHIFT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  barrett_mu_precompute_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SHIFT);

  if (SHIFT < 1 || SHIFT > W || W < 2) begin : g_param_err
    $error("barrett_mu_precompute: SHIFT must lie in 1..W and W must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q;
  logic [W-1:0]  m_q;
  logic [W-1:0]  r_q;
  logic [W-1:0]  q_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          busy_q;
  logic          valid_q;
  logic [W-1:0]  m_out_q;
  logic [W-1:0]  mu_out_q;
  logic          err_out_q;

  logic          dividend_bit;
  logic [W:0]    t;
  logic          q_bit;
  logic [W-1:0]  r_next;

  assign dividend_bit = (cnt_q == CNT_INIT);

  // r < m_q keeps t within W+1 bits; on a failed subtract t < m_q so t[W] is zero.
  always_comb begin
    t      = {r_q, dividend_bit};
    q_bit  = (t >= {1'b0, m_q});
    r_next = t[W-1:0];
    if (q_bit) begin
      r_next = W'(t - {1'b0, m_q});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      m_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      m_out_q   <= '0;
      mu_out_q  <= '0;
      err_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            m_q    <= bus.m_i;
            r_q    <= '0;
            busy_q <= 1'b1;
            if (bus.m_i < W'(2)) begin
              err_q   <= 1'b1;
              q_q     <= '1;
              state_q <= DONE;
            end else begin
              err_q   <= 1'b0;
              q_q     <= '0;
              cnt_q   <= CNT_INIT;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q <= r_next;
          q_q <= {q_q[W-2:0], q_bit};
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle loads the output stage so m_o/mu_o/err_o change together.
          if (valid_q && bus.ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!valid_q) begin
            valid_q   <= 1'b1;
            m_out_q   <= m_q;
            mu_out_q  <= q_q;
            err_out_q <= err_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.m_o     = m_out_q;
  assign bus.mu_o    = mu_out_q;
  assign bus.err_o   = err_out_q;

  // The quotient has SHIFT+1 bits; anything shifted out of the W-bit register must be zero.
  a_quot_msb_zero : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == CALC) |-> !q_q[W-1]);

endmodule

// File: tb/tb_barrett_mu_precompute.sv
// Directed and random checks of barrett_mu_precompute at W = SHIFT = 64.
module tb_barrett_mu_precompute;
  localparam int W     = 64;
  localparam int SHIFT = 64;
  localparam int LAT   = SHIFT + 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  barrett_mu_precompute_if #(.W(W)) bus ();

  barrett_mu_precompute #(.W(W), .SHIFT(SHIFT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [63:0] m;
    logic [63:0] mu;
    logic        err;
    int          gap;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mu(input logic [63:0] m);
    logic [64:0] p;
    p = 65'd1 << SHIFT;
    return 64'(p / {1'b0, m});
  endfunction

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Called at a negedge; gap==0 holds ready_i high from the start edge.
  task automatic run_one(input logic [63:0] m, input logic exp_err, input logic [63:0] exp_mu,
                         input int gap, input string tag);
    int k;
    logic seen;
    bus.m_i     = m;
    bus.start_i = 1'b1;
    bus.ready_i = (gap == 0);
    tick();
    bus.start_i = 1'b0;
    bus.m_i     = ~m;
    chk({tag, " busy_after_start"}, 64'(bus.busy_o), 64'd1);
    chk({tag, " valid_after_start"}, 64'(bus.valid_o), 64'd0);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      tick();
      k++;
      seen = bus.valid_o;
    end
    chk({tag, " latency"}, 64'(k), exp_err ? 64'd1 : 64'(LAT));
    chk({tag, " mu"}, bus.mu_o, exp_mu);
    chk({tag, " err"}, 64'(bus.err_o), 64'(exp_err));
    chk({tag, " m_o"}, bus.m_o, m);
    if (gap > 0) begin
      repeat (gap) tick();
      chk({tag, " valid_held"}, 64'(bus.valid_o), 64'd1);
      bus.ready_i = 1'b1;
    end
    tick();
    chk({tag, " valid_after_hs"}, 64'(bus.valid_o), 64'd0);
    chk({tag, " busy_after_hs"}, 64'(bus.busy_o), 64'd0);
    bus.ready_i = 1'b0;
  endtask

  initial begin
    logic [63:0] mu_hold;
    logic [63:0] rm;
    logic        stable;
    logic        extra;
    int          k;

    vecs[0]  = '{64'd3,                  64'h5555_5555_5555_5555, 1'b0, 0};
    vecs[1]  = '{64'd7,                  64'h2492_4924_9249_2492, 1'b0, 2};
    vecs[2]  = '{64'd2,                  64'h8000_0000_0000_0000, 1'b0, 0};
    vecs[3]  = '{64'h1_0000_0000,        64'h1_0000_0000,         1'b0, 1};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0, 0};
    vecs[5]  = '{64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0};
    vecs[6]  = '{64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3};
    vecs[7]  = '{64'd5,                  64'h3333_3333_3333_3333, 1'b0, 0};
    vecs[8]  = '{64'd10,                 64'h1999_9999_9999_9999, 1'b0, 1};
    vecs[9]  = '{64'h8000_0000_0000_0000, 64'd2,                  1'b0, 0};
    vecs[10] = '{64'h8000_0000_0000_0001, 64'd1,                  1'b0, 0};
    vecs[11] = '{64'd1000,               64'h0041_8937_4BC6_A7EF, 1'b0, 2};

    bus.start_i = 1'b0;
    bus.m_i     = '0;
    bus.ready_i = 1'b0;
    rst_i       = 1'b1;
    repeat (3) tick();
    chk("reset busy", 64'(bus.busy_o), 64'd0);
    chk("reset valid", 64'(bus.valid_o), 64'd0);
    chk("reset err", 64'(bus.err_o), 64'd0);
    chk("reset m_o", bus.m_o, 64'd0);
    chk("reset mu", bus.mu_o, 64'd0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_one(vecs[i].m, vecs[i].err, vecs[i].mu, vecs[i].gap, $sformatf("vec%0d", i));
    end

    // Backpressure with start pulses in CALC and DONE.
    bus.m_i     = 64'd7;
    bus.start_i = 1'b1;
    bus.ready_i = 1'b0;
    tick();
    bus.start_i = 1'b0;
    k = 0;
    repeat (10) begin tick(); k++; end
    bus.m_i     = 64'd9;
    bus.start_i = 1'b1;
    tick();
    k++;
    bus.start_i = 1'b0;
    while (!bus.valid_o && k < 200) begin tick(); k++; end
    chk("bp latency", 64'(k), 64'(LAT));
    chk("bp mu", bus.mu_o, 64'h2492_4924_9249_2492);
    mu_hold = bus.mu_o;
    stable  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.start_i = (c == 3);
      bus.m_i     = 64'd11;
      tick();
      if (!bus.valid_o || !bus.busy_o || bus.mu_o !== mu_hold || bus.m_o !== 64'd7) stable = 1'b0;
    end
    bus.start_i = 1'b0;
    chk("bp stable", 64'(stable), 64'd1);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk("bp busy_after_hs", 64'(bus.busy_o), 64'd0);
    extra = 1'b0;
    repeat (80) begin
      tick();
      if (bus.valid_o || bus.busy_o) extra = 1'b1;
    end
    chk("bp no_second_result", 64'(extra), 64'd0);

    // Reset in the 30th CALC cycle, with start_i high alongside it.
    bus.m_i     = 64'h0123_4567_89AB_CDEF;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (29) tick();
    chk("mid busy_before_rst", 64'(bus.busy_o), 64'd1);
    rst_i       = 1'b1;
    bus.start_i = 1'b1;
    bus.m_i     = 64'd0;
    tick();
    chk("mid busy", 64'(bus.busy_o), 64'd0);
    chk("mid valid", 64'(bus.valid_o), 64'd0);
    chk("mid err", 64'(bus.err_o), 64'd0);
    chk("mid m_o", bus.m_o, 64'd0);
    chk("mid mu", bus.mu_o, 64'd0);
    rst_i       = 1'b0;
    bus.start_i = 1'b0;
    tick();
    chk("mid idle_busy", 64'(bus.busy_o), 64'd0);
    chk("mid idle_valid", 64'(bus.valid_o), 64'd0);

    for (int i = 0; i < 200; i++) begin
      if (i % 4 == 0) rm = 64'($urandom_range(2, 5000));
      else rm = {$urandom, $urandom};
      if (rm < 64'd2) rm = rm + 64'd2;
      run_one(rm, 1'b0, ref_mu(rm), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
